// File: rtl/sm_pkg.sv
// Shared types and default timing for the stepper-motor output stage.
package sm_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_EN_WAIT   = 3'd1,
        ST_IDLE      = 3'd2,
        ST_DIR_SETUP = 3'd3,
        ST_STEP_HIGH = 3'd4,
        ST_STEP_LOW  = 3'd5
    } sm_drv_state_t;

    localparam int POS_W_DEF       = 32;
    localparam int T_EN_SETUP_DEF  = 250;
    localparam int T_DIR_SETUP_DEF = 50;
    localparam int T_STEP_HIGH_DEF = 100;
    localparam int T_STEP_LOW_DEF  = 100;
    localparam int DROP_CNT_W      = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sm_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
module sm_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sm_step_driver.sv
// STEP/DIR/EN output stage with setup/pulse-width timing, position tracking and one-deep request buffer.
// Define SM_LIMIT_EN to synchronise lim_fwd/lim_rev and suppress steps into an asserted limit.
module sm_step_driver
    import sm_pkg::*;
#(
    parameter int POS_W       = POS_W_DEF,
    parameter int T_EN_SETUP  = T_EN_SETUP_DEF,
    parameter int T_DIR_SETUP = T_DIR_SETUP_DEF,
    parameter int T_STEP_HIGH = T_STEP_HIGH_DEF,
    parameter int T_STEP_LOW  = T_STEP_LOW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drv_pulse,
    input  logic                  dir_req,
    input  logic                  drv_en_SM,
    input  logic                  lim_fwd,
    input  logic                  lim_rev,
    input  logic                  clr,
    output logic                  step_out,
    output logic                  dir_out,
    output logic                  en_out,
    output logic [POS_W-1:0]      position,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  limit_fault,
    output logic                  busy,
    output sm_drv_state_t         dbg_state_o
);

    localparam int T_MAX   = max4(T_EN_SETUP, T_DIR_SETUP, T_STEP_HIGH, T_STEP_LOW);
    localparam int TIMER_W = $clog2(T_MAX) + 1;

    sm_drv_state_t         state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  pend_q, pend_d;
    logic                  pulse_q;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic                  en_q, en_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  req;
    logic                  go_step;
    logic                  blocked;

    assign req = drv_pulse & ~pulse_q;

`ifdef SM_LIMIT_EN
    logic lim_fwd_s;
    logic lim_rev_s;
    logic fault_q;

    sm_sync2 u_sync_fwd (.clk(clk), .rst(rst), .d_i(lim_fwd), .q_o(lim_fwd_s));
    sm_sync2 u_sync_rev (.clk(clk), .rst(rst), .d_i(lim_rev), .q_o(lim_rev_s));

    // dir_out is already the direction of the step being decided.
    assign blocked = dir_q ? lim_fwd_s : lim_rev_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (clr) begin
            fault_q <= 1'b0;
        end else if (go_step && blocked) begin
            fault_q <= 1'b1;
        end
    end

    assign limit_fault = fault_q;
`else
    logic unused_lim;
    assign unused_lim  = lim_fwd ^ lim_rev;
    assign blocked     = 1'b0;
    assign limit_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            timer_q <= '0;
            pend_q  <= 1'b0;
            pulse_q <= 1'b0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            en_q    <= 1'b0;
            pos_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            pulse_q <= drv_pulse;
            step_q  <= step_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            pos_q   <= pos_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        step_d  = step_q;
        dir_d   = dir_q;
        en_d    = en_q;
        pos_d   = pos_q;
        drop_d  = drop_q;
        go_step = 1'b0;

        if (!drv_en_SM) begin
            state_d = ST_DISABLED;
            step_d  = 1'b0;
            en_d    = 1'b0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d = ST_EN_WAIT;
                    en_d    = 1'b1;
                    timer_d = TIMER_W'(T_EN_SETUP - 1);
                end
                ST_EN_WAIT: begin
                    if (timer_q == '0) state_d = ST_IDLE;
                    else               timer_d = timer_q - TIMER_W'(1);
                end
                ST_IDLE: begin
                    if (req || pend_q) begin
                        // Serving the buffered request while a new edge arrives re-arms the buffer.
                        pend_d = pend_q & req;
                        if (dir_req != dir_q) begin
                            dir_d   = dir_req;
                            state_d = ST_DIR_SETUP;
                            timer_d = TIMER_W'(T_DIR_SETUP - 1);
                        end else begin
                            go_step = 1'b1;
                        end
                    end
                end
                ST_DIR_SETUP: begin
                    if (timer_q == '0) go_step = 1'b1;
                    else               timer_d = timer_q - TIMER_W'(1);
                end
                ST_STEP_HIGH: begin
                    if (timer_q == '0) begin
                        state_d = ST_STEP_LOW;
                        step_d  = 1'b0;
                        timer_d = TIMER_W'(T_STEP_LOW - 1);
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_STEP_LOW: begin
                    if (timer_q == '0) state_d = ST_IDLE;
                    else               timer_d = timer_q - TIMER_W'(1);
                end
                default: state_d = ST_DISABLED;
            endcase

            if (req && state_q != ST_IDLE && state_q != ST_DISABLED) begin
                if (!pend_q)            pend_d = 1'b1;
                else if (drop_q != '1)  drop_d = drop_q + DROP_CNT_W'(1);
            end

            if (go_step) begin
                if (blocked) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STEP_HIGH;
                    step_d  = 1'b1;
                    timer_d = TIMER_W'(T_STEP_HIGH - 1);
                    pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                end
            end
        end

        if (clr) begin
            pos_d  = '0;
            drop_d = '0;
        end
    end

    assign step_out    = step_q;
    assign dir_out     = dir_q;
    assign en_out      = en_q;
    assign position    = pos_q;
    assign drop_cnt    = drop_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DISABLED);
    assign dbg_state_o = state_q;

endmodule
